pipeline_redirect_ctrl: RTL and testbench
=========================================

Name: pipeline_redirect_ctrl

Overview:
Pipeline sequencer placed around the EX-stage branch-resolve logic of the 5-stage RISC-V core. It turns the EX-stage take-branch/jump decision (Diverge) into PC redirects and IF/ID/EX squashes. It inserts load-use bubbles and holds a redirect that resolves during a memory-stall freeze until the pipeline thaws.

Parameters:
XLEN, 32, width of PC and target addresses
LU_BUBBLES, 1, bubble cycles inserted per load-use hazard (legal 1..3)
CNT_W, 32, width of statistics counters (optional feature only)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
ExValid  in  1  EX holds a real instruction (not a bubble)
Diverge  in  1  EX instruction takes branch/jump
ExTarget  in  XLEN  branch/jump target from EX
ExIsLoad  in  1  EX instruction is a load
ExRd  in  5  EX destination register
IdRs1, IdRs2  in  5 each  ID source registers
IdUsesRs1, IdUsesRs2  in  1 each  ID instruction reads that source
MemStall  in  1  cache miss, whole pipeline frozen
PCSel  out  1  1: next PC = RedirectPC
RedirectPC  out  XLEN  redirect address
StallIF  out  1  hold PC
StallID  out  1  hold IF/ID register
FlushID  out  1  load NOP into IF/ID
FlushEX  out  1  load bubble into ID/EX
Freeze  out  1  all stages hold
RedirectCount  out  CNT_W  redirects issued (optional feature)
BubbleCount  out  CNT_W  load-use bubble cycles (optional feature)

Behaviour:
- States: RUN, PEND, BUBBLE. Registers: PendTarget[XLEN], BubCnt[2].
- Reset (async, rst_n=0): state=RUN, PendTarget=0, BubCnt=0, counters=0. While rst_n=0, every output is forced 0 regardless of inputs.
- Defines:
  - Redir = ExValid & Diverge.
  - LU = ExValid & ExIsLoad & ExRd!=0 & ((IdUsesRs1 & IdRs1==ExRd) | (IdUsesRs2 & IdRs2==ExRd)).
- Freeze = MemStall in every state. While frozen, no state or counter changes except RUN->PEND capture.
- RUN, MemStall=0:
  - Redir: same cycle (0 latency) PCSel=1, RedirectPC=ExTarget, FlushID=1, FlushEX=1. Stay in RUN.
  - else LU: StallIF=1, StallID=1, FlushEX=1. If LU_BUBBLES>1, go to BUBBLE with BubCnt=LU_BUBBLES-1.
  - Redir beats LU (the ID instruction is squashed anyway). No stall is asserted when Redir.
- RUN, MemStall=1:
  - Redir: PendTarget<=ExTarget, go to PEND. PCSel and flushes stay 0.
  - LU is ignored.
- PEND:
  - EX inputs are ignored.
  - While MemStall=1: hold.
  - First cycle MemStall=0: PCSel=1, RedirectPC=PendTarget, FlushID=1, FlushEX=1, then go to RUN.
  - Exactly one redirect is issued per captured branch.
- BUBBLE:
  - Outputs StallIF=1, StallID=1, FlushEX=1 each non-frozen cycle, and BubCnt decrements.
  - At BubCnt=1, the decrement returns the state to RUN.
  - MemStall=1 holds BubCnt.
  - Diverge is ignored (EX holds a bubble).
- Outputs not named in a state are 0. RedirectPC=0 when PCSel=0.
- ExRd=0 never causes a hazard. Both sources matching counts as one hazard.

Optional Feature:
REDIRECT_STATS_EN
- Defined: RedirectCount increments once per cycle with PCSel=1. BubbleCount increments once per cycle with FlushEX=1 caused by LU or BUBBLE. Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counter flops; both ports tied to constant 0.

Test Plan:
- Taken branch: RUN, ExValid=1, Diverge=1, ExTarget=0x1000_0040, MemStall=0 -> same cycle PCSel=1, RedirectPC=0x1000_0040, FlushID=1, FlushEX=1, StallIF=0.
- Load-use: ExIsLoad=1, ExRd=5, IdRs2=5, IdUsesRs2=1, LU_BUBBLES=1 -> one cycle StallIF=StallID=FlushEX=1, next cycle all 0 with hazard cleared.
- Redirect under stall: Diverge=1, ExTarget=0x200, MemStall=1 for 4 cycles with ExTarget changed to 0x300 meanwhile -> Freeze=1 for 4 cycles, then exactly one cycle PCSel=1, RedirectPC=0x200.
- Priority/zero-reg: Redir and LU together -> flushes only, StallIF=0. LU with ExRd=0 -> no stall.
- LU_BUBBLES=3 with MemStall pulsed in the second bubble cycle -> FlushEX asserted for 3 non-frozen cycles, BubbleCount=3 (REDIRECT_STATS_EN).
- Reset mid-PEND: rst_n low during PEND -> all outputs 0 immediately. After release, state RUN, no redirect issued when MemStall drops.

Source files
------------

// File: rtl/pipeline_redirect_ctrl_if.sv
// pipeline_redirect_ctrl_if
//   Bundles the EX/ID hazard inputs and the redirect/stall/flush outputs of
//   pipeline_redirect_ctrl.
//   master : core side. Drives the EX/ID inputs and MemStall, and receives
//            the controls.
//   slave  : the controller.
//   Inputs  : ExValid, Diverge, ExTarget, ExIsLoad, ExRd, IdRs1, IdRs2,
//             IdUsesRs1, IdUsesRs2, MemStall
//   Outputs : PCSel, RedirectPC, StallIF, StallID, FlushID, FlushEX, Freeze,
//             RedirectCount, BubbleCount
interface pipeline_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic            ExValid;
    logic            Diverge;
    logic [XLEN-1:0] ExTarget;
    logic            ExIsLoad;
    logic [4:0]      ExRd;
    logic [4:0]      IdRs1;
    logic [4:0]      IdRs2;
    logic            IdUsesRs1;
    logic            IdUsesRs2;
    logic            MemStall;

    logic             PCSel;
    logic [XLEN-1:0]  RedirectPC;
    logic             StallIF;
    logic             StallID;
    logic             FlushID;
    logic             FlushEX;
    logic             Freeze;
    logic [CNT_W-1:0] RedirectCount;
    logic [CNT_W-1:0] BubbleCount;

    modport master (
        output ExValid, Diverge, ExTarget, ExIsLoad, ExRd, IdRs1, IdRs2,
               IdUsesRs1, IdUsesRs2, MemStall,
        input  PCSel, RedirectPC, StallIF, StallID, FlushID, FlushEX, Freeze,
               RedirectCount, BubbleCount
    );

    modport slave (
        input  ExValid, Diverge, ExTarget, ExIsLoad, ExRd, IdRs1, IdRs2,
               IdUsesRs1, IdUsesRs2, MemStall,
        output PCSel, RedirectPC, StallIF, StallID, FlushID, FlushEX, Freeze,
               RedirectCount, BubbleCount
    );
endinterface

// File: rtl/pipeline_redirect_ctrl.sv
// pipeline_redirect_ctrl
//   Sequencer around the EX-stage branch resolve logic. It does three jobs:
//   - It turns a taken branch or jump into a PC redirect and squashes IF/ID
//     and ID/EX.
//   - It inserts load-use bubbles.
//   - It parks a redirect that resolves during a memory freeze until the
//     pipeline thaws.
//   Controls are combinational from the current state and the inputs. This
//   gives zero-latency redirects, which the EX-resolve timing depends on.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset. While rst_n is low,
//                  every output is held at 0.
//     bus        : pipeline_redirect_ctrl_if.slave
//   Parameters:
//     XLEN       : width of the PC and of the target addresses.
//     LU_BUBBLES : bubble cycles per load-use hazard. Legal range is 1..3.
//     CNT_W      : width of the statistics counters.
//   Optional: define REDIRECT_STATS_EN to add the RedirectCount and
//   BubbleCount counters. Without it, both ports are tied to 0.
module pipeline_redirect_ctrl #(
    parameter int XLEN       = 32,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    pipeline_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, PEND, BUBBLE} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pend_tgt, pend_tgt_nx;
    logic [1:0]      bub_cnt, bub_cnt_nx;

    logic            redir, lu;
    logic            pc_sel, stall, flush_id, flush_ex;
    logic [XLEN-1:0] redirect_pc;

    assign redir = bus.ExValid & bus.Diverge;
    // A load into x0 is never a real producer, so ExRd = 0 cannot raise a
    // hazard. When both sources match, it still counts as a single hazard.
    assign lu = bus.ExValid & bus.ExIsLoad & (bus.ExRd != 5'd0) &
                ((bus.IdUsesRs1 & (bus.IdRs1 == bus.ExRd)) |
                 (bus.IdUsesRs2 & (bus.IdRs2 == bus.ExRd)));

    always_comb begin
        state_nx    = state;
        pend_tgt_nx = pend_tgt;
        bub_cnt_nx  = bub_cnt;
        pc_sel      = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        case (state)
            RUN: begin
                if (bus.MemStall) begin
                    // Frozen: only capture a branch. Load-use is re-evaluated
                    // after the thaw.
                    if (redir) begin
                        pend_tgt_nx = bus.ExTarget;
                        state_nx    = PEND;
                    end
                end else if (redir) begin
                    // The redirect wins over load-use. The stalled ID
                    // instruction is on the wrong path and is squashed anyway.
                    pc_sel      = 1'b1;
                    redirect_pc = bus.ExTarget;
                    flush_id    = 1'b1;
                    flush_ex    = 1'b1;
                end else if (lu) begin
                    stall    = 1'b1;
                    flush_ex = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_nx   = BUBBLE;
                        bub_cnt_nx = 2'(LU_BUBBLES - 1);
                    end
                end
            end
            PEND: begin
                // EX now holds stale data, so only the captured target counts.
                if (!bus.MemStall) begin
                    pc_sel      = 1'b1;
                    redirect_pc = pend_tgt;
                    flush_id    = 1'b1;
                    flush_ex    = 1'b1;
                    state_nx    = RUN;
                end
            end
            BUBBLE: begin
                if (!bus.MemStall) begin
                    stall      = 1'b1;
                    flush_ex   = 1'b1;
                    bub_cnt_nx = bub_cnt - 2'd1;
                    if (bub_cnt == 2'd1) state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pend_tgt <= '0;
            bub_cnt  <= '0;
        end else begin
            state    <= state_nx;
            pend_tgt <= pend_tgt_nx;
            bub_cnt  <= bub_cnt_nx;
        end
    end

    // The outputs are gated by rst_n, so reset silences them immediately
    // rather than at the next clock edge.
    assign bus.PCSel      = rst_n & pc_sel;
    assign bus.RedirectPC = rst_n ? redirect_pc : '0;
    assign bus.StallIF    = rst_n & stall;
    assign bus.StallID    = rst_n & stall;
    assign bus.FlushID    = rst_n & flush_id;
    assign bus.FlushEX    = rst_n & flush_ex;
    assign bus.Freeze     = rst_n & bus.MemStall;

`ifdef REDIRECT_STATS_EN
    logic [CNT_W-1:0] redirect_cnt, bubble_cnt;

    // A FlushEX without PCSel is always a load-use or BUBBLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
            bubble_cnt   <= '0;
        end else begin
            if (pc_sel)              redirect_cnt <= redirect_cnt + 1'b1;
            if (flush_ex && !pc_sel) bubble_cnt   <= bubble_cnt + 1'b1;
        end
    end

    assign bus.RedirectCount = redirect_cnt;
    assign bus.BubbleCount   = bubble_cnt;
`else
    assign bus.RedirectCount = {CNT_W{1'b0}};
    assign bus.BubbleCount   = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Scoreboard bench for pipeline_redirect_ctrl. It builds two instances,
// LU_BUBBLES = 1 and LU_BUBBLES = 3, and drives both with the same stimulus.
// Each cycle, a reference model pushes the expected outputs into a queue per
// instance. A negedge monitor pops each entry and compares it with the DUT.
module tb_pipeline_redirect_ctrl;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic        pcsel;
        logic [31:0] rpc;
        logic        sif, sid, fid, fex, frz;
        logic [31:0] rc, bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v = 0, d = 0, ld = 0, u1 = 0, u2 = 0, ms = 0;
    logic [31:0] tgt = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    pipeline_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) if0 ();
    pipeline_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) if1 ();

    pipeline_redirect_ctrl #(.XLEN(XLEN), .LU_BUBBLES(1), .CNT_W(CNT_W))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipeline_redirect_ctrl #(.XLEN(XLEN), .LU_BUBBLES(3), .CNT_W(CNT_W))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always_comb begin
        if0.ExValid = v;  if0.Diverge = d;  if0.ExTarget = tgt; if0.ExIsLoad = ld;
        if0.ExRd = rd;    if0.IdRs1 = rs1;  if0.IdRs2 = rs2;
        if0.IdUsesRs1 = u1; if0.IdUsesRs2 = u2; if0.MemStall = ms;
        if1.ExValid = v;  if1.Diverge = d;  if1.ExTarget = tgt; if1.ExIsLoad = ld;
        if1.ExRd = rd;    if1.IdRs1 = rs1;  if1.IdRs2 = rs2;
        if1.IdUsesRs1 = u1; if1.IdUsesRs2 = u2; if1.MemStall = ms;
    end

    // Reference model state, kept per instance. It tracks the bubble cycles
    // still owed, a parked redirect (pending flag and target), and the
    // running event counts.
    int          lub[2] = '{1, 3};
    int          owed[2] = '{0, 0};
    bit          pend[2] = '{0, 0};
    logic [31:0] ptgt[2];
    logic [31:0] nred[2];
    logic [31:0] nbub[2];
    exp_t q0[$];
    exp_t q1[$];

    task automatic model_step(input int i, output exp_t e);
        bit hazard, taken;
        e = '0;
        if (!rst_n) begin
            owed[i] = 0; pend[i] = 0; ptgt[i] = '0; nred[i] = '0; nbub[i] = '0;
            return;
        end
        taken  = v && d;
        hazard = v && ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.frz = ms;
`ifdef REDIRECT_STATS_EN
        e.rc = nred[i];
        e.bc = nbub[i];
`endif
        if (ms) begin
            // Frozen cycle: the only possible change is parking a new branch.
            if (!pend[i] && owed[i] == 0 && taken) begin
                pend[i] = 1; ptgt[i] = tgt;
            end
        end else if (pend[i]) begin
            e.pcsel = 1; e.rpc = ptgt[i]; e.fid = 1; e.fex = 1; pend[i] = 0;
        end else if (owed[i] > 0) begin
            e.sif = 1; e.sid = 1; e.fex = 1; owed[i]--;
        end else if (taken) begin
            e.pcsel = 1; e.rpc = tgt; e.fid = 1; e.fex = 1;
        end else if (hazard) begin
            e.sif = 1; e.sid = 1; e.fex = 1; owed[i] = lub[i] - 1;
        end
        if (e.pcsel) nred[i] = nred[i] + 1;
        if (e.sif)   nbub[i] = nbub[i] + 1;
    endtask

    task automatic cyc(input logic r, v_, d_, input logic [31:0] t_, input logic ld_,
                       input logic [4:0] rd_, rs1_, rs2_, input logic u1_, u2_, ms_);
        exp_t e0, e1;
        @(posedge clk);
        #1;
        rst_n = r; v = v_; d = d_; tgt = t_; ld = ld_; rd = rd_;
        rs1 = rs1_; rs2 = rs2_; u1 = u1_; u2 = u2_; ms = ms_;
        model_step(0, e0);
        model_step(1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic idle(input logic ms_);
        cyc(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ms_);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        cyc_n++;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            g = {if0.PCSel, if0.RedirectPC, if0.StallIF, if0.StallID, if0.FlushID,
                 if0.FlushEX, if0.Freeze, if0.RedirectCount, if0.BubbleCount};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL lub1 cyc%0d got=%h exp=%h", cyc_n, g, e);
            end
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            g = {if1.PCSel, if1.RedirectPC, if1.StallIF, if1.StallID, if1.FlushID,
                 if1.FlushEX, if1.Freeze, if1.RedirectCount, if1.BubbleCount};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL lub3 cyc%0d got=%h exp=%h", cyc_n, g, e);
            end
        end
    end

    initial begin
        // Reset with active inputs: every output must stay 0.
        cyc(0, 1, 1, 32'hDEAD_BEEF, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1);
        cyc(0, 1, 1, 32'h1234_5678, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle(0);
        // Taken branch.
        cyc(1, 1, 1, 32'h1000_0040, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle(0);
        // Load-use through rs2.
        cyc(1, 1, 0, 32'h0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0);
        repeat (3) idle(0);
        // Redirect during a freeze. The target changes while frozen.
        cyc(1, 1, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        repeat (3) cyc(1, 1, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        idle(0);
        idle(0);
        // Redirect and load-use together, then load-use with rd = x0.
        cyc(1, 1, 1, 32'h440, 1, 5'd7, 5'd7, 5'd7, 1, 1, 0);
        cyc(1, 1, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        idle(0);
        // Load-use with a freeze in the second bubble cycle.
        cyc(1, 1, 0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0);
        idle(1);
        repeat (3) idle(0);
        // Reset while a redirect is parked: no redirect after release.
        cyc(1, 1, 1, 32'h880, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        cyc(0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        idle(1);
        repeat (2) idle(0);
        // Random traffic with a small register range so hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0), $urandom(), ($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end
        idle(0);
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d/%0d need=0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
